// File: rtl/decoder_3bit.sv
// decoder_3bit: 3-to-8 one-hot decoder with a combinational output and a registered
// capture path that flags valid captures and changes from the previously captured code.
module decoder_3bit #(
  parameter bit ACTIVE_LOW               = 1'b0,
  parameter bit CAPTURE_ON_RESET_RELEASE = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] in,
  input  logic       en,
  output logic [7:0] out,
  output logic [7:0] out_q,
  output logic       out_vld,
  output logic       chg
);
  logic [7:0] dec;
  logic [7:0] q;
  logic [2:0] last_code;
  logic       have_code;
  logic       cap;
  assign dec = 8'(1) << in;
  assign out = ACTIVE_LOW ? ~dec : dec;
  assign out_q = ACTIVE_LOW ? ~q : q;
  // The reserved capture mode is defined to behave exactly like the default.
  assign cap = en & (CAPTURE_ON_RESET_RELEASE | 1'b1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q         <= '0;
      out_vld   <= 1'b0;
      chg       <= 1'b0;
      last_code <= '0;
      have_code <= 1'b0;
    end else if (cap) begin
      q         <= dec;
      out_vld   <= 1'b1;
      chg       <= have_code && (in != last_code);
      last_code <= in;
      have_code <= 1'b1;
    end else begin
      out_vld   <= 1'b0;
      chg       <= 1'b0;
    end
  end
endmodule

// File: tb/tb_decoder_3bit.sv
// tb_decoder_3bit: directed and random checks of both output polarities against a
// reference model built from a history of captured codes.
module tb_decoder_3bit;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] in;
  logic       en;
  logic [7:0] out0, out_q0, out1, out_q1;
  logic       vld0, chg0, vld1, chg1;
  int         errors = 0;
  int         checks = 0;
  logic [2:0] hist[$];
  logic [7:0] m_q;
  logic       m_vld, m_chg;

  decoder_3bit #(.ACTIVE_LOW(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in(in), .en(en),
    .out(out0), .out_q(out_q0), .out_vld(vld0), .chg(chg0)
  );
  decoder_3bit #(.ACTIVE_LOW(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in(in), .en(en),
    .out(out1), .out_q(out_q1), .out_vld(vld1), .chg(chg1)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] onehot(input logic [2:0] c);
    return 8'(2 ** int'(c));
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".out"}, out0, onehot(in));
    chk({tag, ".out_n"}, out1, ~onehot(in));
    chk({tag, ".out_q"}, out_q0, m_q);
    chk({tag, ".out_q_n"}, out_q1, ~m_q);
    chk({tag, ".vld"}, {7'd0, vld0}, {7'd0, m_vld});
    chk({tag, ".vld_n"}, {7'd0, vld1}, {7'd0, m_vld});
    chk({tag, ".chg"}, {7'd0, chg0}, {7'd0, m_chg});
    chk({tag, ".chg_n"}, {7'd0, chg1}, {7'd0, m_chg});
  endtask

  // Called at a falling edge: drive, let one rising edge pass, check at the next falling edge.
  task automatic step(input string tag, input logic e, input logic [2:0] c);
    en = e;
    in = c;
    @(posedge clk);
    if (e) begin
      m_chg = (hist.size() > 0) && (hist[$] != c);
      hist.push_back(c);
      m_q   = onehot(c);
      m_vld = 1'b1;
    end else begin
      m_vld = 1'b0;
      m_chg = 1'b0;
    end
    @(negedge clk);
    chk_all(tag);
  endtask

  // Asserts reset mid-phase, checks the asynchronous effect, releases on a falling edge.
  task automatic reset_pulse(input string tag);
    #2 rst_n = 1'b0;
    hist.delete();
    m_q = '0; m_vld = 1'b0; m_chg = 1'b0;
    #1 chk_all(tag);
    in = in + 3'd1;
    #1 chk_all({tag, ".track"});
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; in = '0;
    m_q = '0; m_vld = 1'b0; m_chg = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in = 3'(i);
      #10 chk_all("sweep");
    end
    in = 3'b110;
    #10 chk_all("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    step("cap101", 1'b1, 3'b101);
    step("cap011", 1'b1, 3'b011);
    step("cap011b", 1'b1, 3'b011);
    step("hold0", 1'b0, 3'b000);
    step("hold1", 1'b0, 3'b111);
    step("hold2", 1'b0, 3'b010);
    step("al_cap", 1'b1, 3'b011);
    reset_pulse("al_rst");
    step("rc_a", 1'b1, 3'b010);
    reset_pulse("rc_rst");
    step("rc_b", 1'b1, 3'b010);
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 39) == 0) reset_pulse("rnd_rst");
      step("rnd", $urandom_range(0, 3) != 0, 3'($urandom));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/decoder_3bit.md
DECODER_3BIT -- requirements
Module: decoder_3bit

Interface
REQ-001 Parameter ACTIVE_LOW, default 0, output polarity: 0 = selected line driven 1, 1 = selected line driven 0 with all others 1.
REQ-002 Parameter CAPTURE_ON_RESET_RELEASE, default 0, meaning: 0 = no capture in the first edge after reset release unless en=1; 1 is reserved and SHALL behave identically to 0.
REQ-003 clk  input  1  single clock, rising-edge active; the block SHALL have exactly one clock.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in  input  3  binary code to decode.
REQ-006 en  input  1  capture enable for the registered path.
REQ-007 out  output  8  combinational one-hot decode of in.
REQ-008 out_q  output  8  registered one-hot decode of in.
REQ-009 out_vld  output  1  registered valid, high for one cycle per capture.
REQ-010 chg  output  1  registered pulse: captured code differs from the previously captured code.

Function
REQ-011 out SHALL be purely combinational from in: out[i] active iff in == i, all other bits inactive, for i = 0..7.
REQ-012 out SHALL NOT depend on clk, rst_n or en, and SHALL be correct even when those inputs are unconnected or held in reset.
REQ-013 Exactly one bit of out SHALL be active for every 2-state value of in; zero-latency, settling within the same delta/time step.
REQ-014 ACTIVE_LOW=1 SHALL bitwise-invert out and out_q, and SHALL NOT affect out_vld or chg.
REQ-015 On a rising clk edge with rst_n=1 and en=1: out_q <= decode(in), out_vld <= 1; one-cycle latency.
REQ-016 On a rising clk edge with rst_n=1 and en=0: out_q SHALL hold, out_vld <= 0, chg <= 0.
REQ-017 The block SHALL keep an internal 3-bit last-code register and a 1-bit "have-code" flag, both updated on every capture.
REQ-018 chg <= 1 on a capture iff have-code=1 and in != last-code; the first capture after reset SHALL give chg=0.
REQ-019 Back-to-back captures with en held high SHALL produce out_vld=1 every cycle; chg SHALL be evaluated independently per cycle.

Reset
REQ-020 rst_n=0 SHALL immediately (asynchronously) force out_q to all-inactive (8'h00 for ACTIVE_LOW=0, 8'hFF for ACTIVE_LOW=1), out_vld=0, chg=0, last-code=0, have-code=0.
REQ-021 Reset release SHALL be synchronized to clk. The first capture SHALL occur on the first rising edge with rst_n=1 and en=1.
REQ-022 Reset asserted mid-operation SHALL discard the held code; out SHALL continue to follow in throughout reset.

Verification
REQ-023 Combinational sweep, no clock: in = 000,001,...,111 each for 10 ns -> out = 00000001, 00000010, 00000100, 00001000, 00010000, 00100000, 01000000, 10000000.
REQ-024 rst_n=0 with in=110 -> out=01000000, out_q=00000000, out_vld=0, chg=0.
REQ-025 Release reset, en=1, in=101, one edge -> out_q=00100000, out_vld=1, chg=0; next edge in=011 -> out_q=00001000, chg=1; next edge in=011 -> chg=0.
REQ-026 en=0 for 3 edges while in changes -> out_q holds 00001000, out_vld=0, chg=0, out tracks in.
REQ-027 ACTIVE_LOW=1, in=011, capture -> out=11110111, out_q=11110111; assert rst_n -> out_q=11111111 immediately.
REQ-028 rst_n pulsed low between captures of in=010 and in=010 -> out_q = 00000100 after recapture, chg=0 (have-code cleared).
